// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID-side fields in, EX-side pipeline register out,
// plus the hazard/flush controls and performance counters.
interface id_ex_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             ID_valid;
   logic [4:0]       ID_rs1_addr;
   logic [4:0]       ID_rs2_addr;
   logic [4:0]       ID_rd_addr;
   logic             ID_use_rs1;
   logic             ID_use_rs2;
   logic [XLEN-1:0]  ID_rs1_data;
   logic [XLEN-1:0]  ID_rs2_data;
   logic [XLEN-1:0]  ID_imm;
   logic [XLEN-1:0]  ID_pc;
   logic [15:0]      ID_ctrl;
   logic             ID_MemRead;
   logic [3:0]       ID_MemWrite;
   logic             ID_RegWrite;

   logic             mem_stall;
   logic             branch_flush;
   logic             clr_cnt;

   logic             EX_valid;
   logic [4:0]       EX_rs1_addr;
   logic [4:0]       EX_rs2_addr;
   logic [4:0]       EX_rd_addr;
   logic [XLEN-1:0]  EX_rs1_data;
   logic [XLEN-1:0]  EX_rs2_data;
   logic [XLEN-1:0]  EX_imm;
   logic [XLEN-1:0]  EX_pc;
   logic [15:0]      EX_ctrl;
   logic             EX_MemRead;
   logic [3:0]       EX_MemWrite;
   logic             EX_RegWrite;

   logic             stall_IF_ID;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ID_valid, ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_use_rs1, ID_use_rs2,
             ID_rs1_data, ID_rs2_data, ID_imm, ID_pc, ID_ctrl, ID_MemRead,
             ID_MemWrite, ID_RegWrite, mem_stall, branch_flush, clr_cnt,
      input  EX_valid, EX_rs1_addr, EX_rs2_addr, EX_rd_addr, EX_rs1_data,
             EX_rs2_data, EX_imm, EX_pc, EX_ctrl, EX_MemRead, EX_MemWrite,
             EX_RegWrite, stall_IF_ID, bubble_cnt, flush_cnt
   );

   modport slave (
      input  ID_valid, ID_rs1_addr, ID_rs2_addr, ID_rd_addr, ID_use_rs1, ID_use_rs2,
             ID_rs1_data, ID_rs2_data, ID_imm, ID_pc, ID_ctrl, ID_MemRead,
             ID_MemWrite, ID_RegWrite, mem_stall, branch_flush, clr_cnt,
      output EX_valid, EX_rs1_addr, EX_rs2_addr, EX_rd_addr, EX_rs1_data,
             EX_rs2_data, EX_imm, EX_pc, EX_ctrl, EX_MemRead, EX_MemWrite,
             EX_RegWrite, stall_IF_ID, bubble_cnt, flush_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and saturating bubble/flush counters.
//
// Per-cycle action, highest priority first:
//   mem_stall    | hold EX register and counters, stall IF/ID
//   branch_flush | bubble into EX, ID instruction squashed, count flush
//   load_use     | bubble into EX, stall IF/ID so ID is re-presented, count bubble
//   otherwise    | capture ID into EX
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst,
   id_ex_stage_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};

   logic hazard_rs1;
   logic hazard_rs2;
   logic load_use;
   logic insert_bubble;

   // Load in EX whose rd is read by the instruction in ID; x0 never hazards.
   always_comb begin
      hazard_rs1 = bus.ID_use_rs1 && (bus.ID_rs1_addr == bus.EX_rd_addr);
      hazard_rs2 = bus.ID_use_rs2 && (bus.ID_rs2_addr == bus.EX_rd_addr);
      load_use   = bus.ID_valid && bus.EX_valid && bus.EX_MemRead &&
                   (bus.EX_rd_addr != 5'd0) && (hazard_rs1 || hazard_rs2);
   end

   // A flush squashes ID, so it overrides the hazard stall.
   always_comb begin
      insert_bubble   = bus.branch_flush || load_use;
      bus.stall_IF_ID = bus.mem_stall || (!bus.branch_flush && load_use);
   end

   // EX pipeline register; a bubble zeroes addresses too so forwarding never matches it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.EX_valid    <= 1'b0;
         bus.EX_rs1_addr <= 5'd0;
         bus.EX_rs2_addr <= 5'd0;
         bus.EX_rd_addr  <= 5'd0;
         bus.EX_rs1_data <= XLEN_ZERO;
         bus.EX_rs2_data <= XLEN_ZERO;
         bus.EX_imm      <= XLEN_ZERO;
         bus.EX_pc       <= XLEN_ZERO;
         bus.EX_ctrl     <= 16'd0;
         bus.EX_MemRead  <= 1'b0;
         bus.EX_MemWrite <= 4'd0;
         bus.EX_RegWrite <= 1'b0;
      end else if (bus.mem_stall) begin
         // freeze
      end else if (insert_bubble) begin
         bus.EX_valid    <= 1'b0;
         bus.EX_rs1_addr <= 5'd0;
         bus.EX_rs2_addr <= 5'd0;
         bus.EX_rd_addr  <= 5'd0;
         bus.EX_rs1_data <= XLEN_ZERO;
         bus.EX_rs2_data <= XLEN_ZERO;
         bus.EX_imm      <= XLEN_ZERO;
         bus.EX_pc       <= XLEN_ZERO;
         bus.EX_ctrl     <= 16'd0;
         bus.EX_MemRead  <= 1'b0;
         bus.EX_MemWrite <= 4'd0;
         bus.EX_RegWrite <= 1'b0;
      end else begin
         // side-effecting controls are gated by ID_valid; data is don't-care when invalid
         bus.EX_valid    <= bus.ID_valid;
         bus.EX_rs1_addr <= bus.ID_rs1_addr;
         bus.EX_rs2_addr <= bus.ID_rs2_addr;
         bus.EX_rd_addr  <= bus.ID_rd_addr;
         bus.EX_rs1_data <= bus.ID_rs1_data;
         bus.EX_rs2_data <= bus.ID_rs2_data;
         bus.EX_imm      <= bus.ID_imm;
         bus.EX_pc       <= bus.ID_pc;
         bus.EX_ctrl     <= bus.ID_valid ? bus.ID_ctrl : 16'd0;
         bus.EX_MemRead  <= bus.ID_valid && bus.ID_MemRead;
         bus.EX_MemWrite <= bus.ID_valid ? bus.ID_MemWrite : 4'd0;
         bus.EX_RegWrite <= bus.ID_valid && bus.ID_RegWrite;
      end
   end

   // Saturating event counters; clear wins over increment and works during a stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.bubble_cnt <= '0;
         bus.flush_cnt  <= '0;
      end else if (bus.clr_cnt) begin
         bus.bubble_cnt <= '0;
         bus.flush_cnt  <= '0;
      end else if (!bus.mem_stall) begin
         if (bus.branch_flush) begin
            if (bus.flush_cnt != CNT_MAX) bus.flush_cnt <= bus.flush_cnt + 1'b1;
         end else if (load_use) begin
            if (bus.bubble_cnt != CNT_MAX) bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when an
// instruction is presented and compared after the next clock edge.
module tb_id_ex_stage;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int K_CAP  = 0;
   localparam int K_BUB  = 1;
   localparam int K_HOLD = 2;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [15:0] ctrl;
      logic        memread;
      logic [3:0]  memwrite;
      logic        regwrite;
      logic        chk_data;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t q[$];
   exp_t last_exp;

   id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_instr(input logic valid, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic use1, input logic use2,
                            input logic memread, input logic regwrite, input logic [31:0] pc);
      bus.ID_valid    = valid;
      bus.ID_rd_addr  = rd;
      bus.ID_rs1_addr = rs1;
      bus.ID_rs2_addr = rs2;
      bus.ID_use_rs1  = use1;
      bus.ID_use_rs2  = use2;
      bus.ID_MemRead  = memread;
      bus.ID_RegWrite = regwrite;
      bus.ID_MemWrite = 4'h0;
      bus.ID_pc       = pc;
      bus.ID_rs1_data = {pc[15:0], 16'h1111};
      bus.ID_rs2_data = ~pc;
      bus.ID_imm      = pc ^ 32'h5a5a_0f0f;
      bus.ID_ctrl     = {pc[7:0], rd, 3'b101};
   endtask

   task automatic chk_zero_ex(input string tag);
      chk({tag, "_valid"}, {31'd0, bus.EX_valid}, 32'd0);
      chk({tag, "_rd"}, {27'd0, bus.EX_rd_addr}, 32'd0);
      chk({tag, "_rs1"}, {27'd0, bus.EX_rs1_addr}, 32'd0);
      chk({tag, "_ctrl"}, {16'd0, bus.EX_ctrl}, 32'd0);
      chk({tag, "_regwrite"}, {31'd0, bus.EX_RegWrite}, 32'd0);
      chk({tag, "_pc"}, bus.EX_pc, 32'd0);
   endtask

   task automatic chk_cnt(input string tag, input int exp_bub, input int exp_fl);
      chk({tag, "_bubble_cnt"}, {28'd0, bus.bubble_cnt}, exp_bub);
      chk({tag, "_flush_cnt"}, {28'd0, bus.flush_cnt}, exp_fl);
   endtask

   // Queue the expectation for this cycle, check stall before the edge, compare EX after it.
   task automatic tick(input string tag, input int kind, input logic exp_stall);
      exp_t e;
      exp_t got;
      e = '0;
      case (kind)
         K_CAP: begin
            e.valid    = bus.ID_valid;
            e.rs1      = bus.ID_rs1_addr;
            e.rs2      = bus.ID_rs2_addr;
            e.rd       = bus.ID_rd_addr;
            e.rs1_data = bus.ID_rs1_data;
            e.rs2_data = bus.ID_rs2_data;
            e.imm      = bus.ID_imm;
            e.pc       = bus.ID_pc;
            e.ctrl     = bus.ID_valid ? bus.ID_ctrl : 16'd0;
            e.memread  = bus.ID_valid & bus.ID_MemRead;
            e.memwrite = bus.ID_valid ? bus.ID_MemWrite : 4'd0;
            e.regwrite = bus.ID_valid & bus.ID_RegWrite;
            e.chk_data = bus.ID_valid;
         end
         K_BUB: e.chk_data = 1'b1;
         default: e = last_exp;
      endcase
      q.push_back(e);
      last_exp = e;
      #1;
      chk({tag, "_stall"}, {31'd0, bus.stall_IF_ID}, {31'd0, exp_stall});
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk({tag, "_valid"}, {31'd0, bus.EX_valid}, {31'd0, got.valid});
      chk({tag, "_regwrite"}, {31'd0, bus.EX_RegWrite}, {31'd0, got.regwrite});
      chk({tag, "_memread"}, {31'd0, bus.EX_MemRead}, {31'd0, got.memread});
      chk({tag, "_memwrite"}, {28'd0, bus.EX_MemWrite}, {28'd0, got.memwrite});
      chk({tag, "_ctrl"}, {16'd0, bus.EX_ctrl}, {16'd0, got.ctrl});
      if (got.chk_data) begin
         chk({tag, "_rd"}, {27'd0, bus.EX_rd_addr}, {27'd0, got.rd});
         chk({tag, "_rs1"}, {27'd0, bus.EX_rs1_addr}, {27'd0, got.rs1});
         chk({tag, "_rs2"}, {27'd0, bus.EX_rs2_addr}, {27'd0, got.rs2});
         chk({tag, "_rs1_data"}, bus.EX_rs1_data, got.rs1_data);
         chk({tag, "_rs2_data"}, bus.EX_rs2_data, got.rs2_data);
         chk({tag, "_imm"}, bus.EX_imm, got.imm);
         chk({tag, "_pc"}, bus.EX_pc, got.pc);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      last_exp = '0;
      rst = 1'b0;
      bus.mem_stall    = 1'b0;
      bus.branch_flush = 1'b0;
      bus.clr_cnt      = 1'b0;
      set_instr(1'b1, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
                1'b1, 1'b1, $urandom);
      bus.ID_MemWrite = 4'hf;

      // reset holds everything at zero even while clocking random inputs
      repeat (3) @(posedge clk);
      #1;
      chk_zero_ex("reset");
      chk_cnt("reset", 0, 0);
      chk("reset_stall", {31'd0, bus.stall_IF_ID}, 32'd0);
      bus.mem_stall = 1'b1;
      #1;
      chk("reset_stall_mem", {31'd0, bus.stall_IF_ID}, 32'd1);
      bus.mem_stall = 1'b0;

      // add x3,x1,x2
      rst = 1'b1;
      set_instr(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
      tick("add_x3", K_CAP, 1'b0);

      // lw x5 ; add x6,x5,x1 -> one bubble then the add
      set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h104);
      tick("lw_x5", K_CAP, 1'b0);
      set_instr(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h108);
      tick("lu_bubble", K_BUB, 1'b1);
      tick("lu_add", K_CAP, 1'b0);
      chk_cnt("lu", 1, 0);

      // lw x5 ; lui x5 (reads nothing) -> no stall
      set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10c);
      tick("lw_x5b", K_CAP, 1'b0);
      set_instr(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110);
      tick("lui_x5", K_CAP, 1'b0);

      // lw x0 ; add x6,x0,x0 -> no stall
      set_instr(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h114);
      tick("lw_x0", K_CAP, 1'b0);
      set_instr(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h118);
      tick("add_x0", K_CAP, 1'b0);
      chk_cnt("nonuse", 1, 0);

      // one load, two dependents: only the first bubbles
      set_instr(1'b1, 5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11c);
      tick("lw_x7", K_CAP, 1'b0);
      set_instr(1'b1, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h120);
      tick("dep1_bubble", K_BUB, 1'b1);
      tick("dep1_add", K_CAP, 1'b0);
      set_instr(1'b1, 5'd9, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h124);
      tick("dep2_add", K_CAP, 1'b0);
      chk_cnt("b2b", 2, 0);

      // branch flush on top of a load-use: flush wins
      set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h128);
      tick("lw_x5c", K_CAP, 1'b0);
      set_instr(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12c);
      bus.branch_flush = 1'b1;
      tick("flush_lu", K_BUB, 1'b0);
      bus.branch_flush = 1'b0;
      chk_cnt("flush_lu", 2, 1);
      set_instr(1'b1, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
      tick("after_flush", K_CAP, 1'b0);

      // mem_stall for 3 cycles over a load-use, then exactly one bubble
      set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h204);
      tick("lw_x5d", K_CAP, 1'b0);
      set_instr(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h208);
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) tick("ms_hold", K_HOLD, 1'b1);
      chk_cnt("ms_hold", 2, 1);
      bus.mem_stall = 1'b0;
      tick("ms_bubble", K_BUB, 1'b1);
      tick("ms_add", K_CAP, 1'b0);
      chk_cnt("ms_lu", 3, 1);

      // mem_stall over branch_flush: flush applied once the stall drops
      set_instr(1'b1, 5'd11, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20c);
      tick("lw_x11", K_CAP, 1'b0);
      set_instr(1'b1, 5'd12, 5'd11, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h210);
      bus.mem_stall    = 1'b1;
      bus.branch_flush = 1'b1;
      tick("msf_hold", K_HOLD, 1'b1);
      tick("msf_hold", K_HOLD, 1'b1);
      chk_cnt("msf_hold", 3, 1);
      bus.mem_stall = 1'b0;
      tick("msf_flush", K_BUB, 1'b0);
      bus.branch_flush = 1'b0;
      chk_cnt("msf", 3, 2);
      set_instr(1'b1, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
      tick("add_x13", K_CAP, 1'b0);

      // invalid ID: controls forced to zero
      set_instr(1'b0, 5'd14, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h304);
      bus.ID_MemWrite = 4'hf;
      tick("invalid", K_CAP, 1'b0);

      // 20 more load-use events saturate the 4-bit bubble counter
      for (int i = 0; i < 20; i++) begin
         set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400 + 32'(i * 8));
         tick("sat_lw", K_CAP, 1'b0);
         set_instr(1'b1, 5'd6, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 32'h404 + 32'(i * 8));
         tick("sat_bubble", K_BUB, 1'b1);
         tick("sat_add", K_CAP, 1'b0);
      end
      chk_cnt("saturate", 15, 2);

      // clr_cnt acts during mem_stall
      bus.mem_stall = 1'b1;
      bus.clr_cnt   = 1'b1;
      tick("clr_hold", K_HOLD, 1'b1);
      bus.clr_cnt   = 1'b0;
      bus.mem_stall = 1'b0;
      chk_cnt("clr", 0, 0);

      // async reset in the middle of a pending load-use
      set_instr(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500);
      tick("rst_lw", K_CAP, 1'b0);
      set_instr(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h504);
      #1;
      chk("rst_pre_stall", {31'd0, bus.stall_IF_ID}, 32'd1);
      rst = 1'b0;
      #1;
      chk_zero_ex("rst_mid");
      chk("rst_mid_stall", {31'd0, bus.stall_IF_ID}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      last_exp = '0;
      tick("rst_after", K_CAP, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
